// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder slice per clock, carry recirculated in a flop.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;

    full_adder slice (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (s),
        .cout (c)
    );

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sh_s  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_s  <= {s, sh_s[WIDTH-1:1]};
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {s, sh_s[WIDTH-1:1]};
                        cout  <= c;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB slice
                        ovf   <= carry ^ c;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
